// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_pkg : shared types and helpers for the pipelined add/sub unit  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // Subtraction is A + ~B + 1, so B is inverted bit-wise and the carry forced.
  function automatic logic eff_b_bit(input logic b, input logic sub);
    return b ^ sub;
  endfunction

  function automatic logic eff_cin(input logic cin, input logic sub);
    return sub ? 1'b1 : cin;
  endfunction

  // Returns {carry_out, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_adder_if : operand/result handshake bundle                 |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_slice : SEG-bit combinational ripple of full-adder cells       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_slice
  import adder_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  always_comb begin
    logic w_c;
    s     = '0;
    c_msb = 1'b0;
    w_c   = cin;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) c_msb = w_c;
      {w_c, s[i]} = full_add(a[i], b[i], w_c);
    end
    cout = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_adder : WIDTH-bit add/sub, one SEG-bit slice per stage,    |
// |                   valid/ready with a single global stall enable      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_adder_if.slave  bus
);

  localparam int STAGES = num_stages(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end

  op_e              w_op;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             w_out_v;
  logic             w_adv;
  logic             r_ovf;

  assign w_op      = op_e'(bus.sub);
  assign w_sub     = (w_op == OP_SUB);
  assign w_cin_eff = eff_cin(bus.cin, w_sub);

  always_comb begin
    w_b_eff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_b_eff[i] = eff_b_bit(bus.b[i], w_sub);
    end
  end

  // Whole pipeline moves as one; a held result freezes every stage.
  assign w_adv        = !w_out_v || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic              w_v_in;
    logic              w_c_in;
    logic [REM-1:0]    w_a_rem;
    logic [REM-1:0]    w_b_rem;
    logic [SEG-1:0]    w_s;
    logic              w_co;
    logic              w_cm;
    logic [LO+SEG-1:0] w_s_nxt;

    logic              r_v;
    logic              r_c;
    logic [LO+SEG-1:0] r_s;

    if (k == 0) begin : g_head
      assign w_v_in  = bus.in_valid;
      assign w_c_in  = w_cin_eff;
      assign w_a_rem = bus.a;
      assign w_b_rem = w_b_eff;
      assign w_s_nxt = w_s;
    end else begin : g_body
      assign w_v_in  = g_stage[k-1].r_v;
      assign w_c_in  = g_stage[k-1].r_c;
      assign w_a_rem = g_stage[k-1].g_skew.r_a;
      assign w_b_rem = g_stage[k-1].g_skew.r_b;
      assign w_s_nxt = {w_s, g_stage[k-1].r_s};
    end

    adder_slice #(
      .SEG (SEG)
    ) u_slice (
      .a     (w_a_rem[SEG-1:0]),
      .b     (w_b_rem[SEG-1:0]),
      .cin   (w_c_in),
      .s     (w_s),
      .cout  (w_co),
      .c_msb (w_cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v_in;
        r_c <= w_co;
        r_s <= w_s_nxt;
      end
    end

    // Operand bits not yet summed ride along until their slice is reached.
    if (k < STAGES - 1) begin : g_skew
      logic [REM-SEG-1:0] r_a;
      logic [REM-SEG-1:0] r_b;
      logic               w_unused_cm;

      assign w_unused_cm = w_cm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_rem[REM-1:SEG];
          r_b <= w_b_rem[REM-1:SEG];
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_cm ^ w_co;
        end
      end

      assign w_out_v       = r_v;
      assign bus.out_valid = r_v;
      assign bus.sum       = r_s;
      assign bus.cout      = r_c;
      assign bus.ovf       = r_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipelined_adder : randomized scoreboard bench for pipelined_adder |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipelined_adder;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int LAT   = WIDTH / SEG;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder #(
    .WIDTH (WIDTH),
    .SEG   (SEG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_sent   = 0;
  int   n_recv   = 0;
  bit   saw_block = 1'b0;
  res_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    int unsigned ua, ub, tot;
    int          sa, sb, sres;
    ua = a;
    ub = b;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r.sum  = 16'(ua - ub);
      r.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      tot    = ua + ub + int'(cin);
      r.sum  = 16'(tot);
      r.cout = (tot > 32'hFFFF);
      sres   = sa + sb + int'(cin);
    end
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick16();
    case ($urandom_range(5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  initial begin
    bit               prev_stall;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout, held_ovf;
    res_t             e;
    prev_stall = 1'b0;
    held_sum   = '0;
    held_cout  = 1'b0;
    held_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (bus.out_valid && !bus.out_ready && !bus.in_ready) saw_block = 1'b1;
        if (prev_stall) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_sum",   bus.sum,  held_sum);
          check("hold_cout",  bus.cout, held_cout);
          check("hold_ovf",   bus.ovf,  held_ovf);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", bus.out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_sum",  bus.sum,  e.sum);
            check("sb_cout", bus.cout, e.cout);
            check("sb_ovf",  bus.ovf,  e.ovf);
            n_recv++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
          n_sent++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        held_sum   = bus.sum;
        held_cout  = bus.cout;
        held_ovf   = bus.ovf;
      end
    end
  end

  task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub,
                      input logic [WIDTH-1:0] esum, input logic ec, input logic eo,
                      input string tag);
    int lat;
    bit got;
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    @(negedge clk);
    check({tag, "_accept"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    check({tag, "_lat"},  lat, LAT);
    check({tag, "_sum"},  bus.sum,  esum);
    check({tag, "_cout"}, bus.cout, ec);
    check({tag, "_ovf"},  bus.ovf,  eo);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int  s0, r0, cyc;
    bit  hold;

    bus.in_valid  = 1'b1;
    bus.a         = 16'hAAAA;
    bus.b         = 16'h5555;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_sum",       bus.sum, 0);
      check("rst_cout",      bus.cout, 0);
      check("rst_in_ready",  bus.in_ready, 1);
    end

    beat(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, "add_basic");
    beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple");
    beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    beat(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    beat(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    drain("directed");

    // Backpressure: 8 beats, consumer stalls for 5 cycles mid-stream.
    s0   = n_sent;
    r0   = n_recv;
    cyc  = 0;
    hold = 1'b0;
    while ((n_sent - s0) < 8 && cyc < 100) begin
      @(posedge clk); #1;
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      if (!hold) begin
        bus.a   = pick16();
        bus.b   = pick16();
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
      end
      bus.in_valid = 1'b1;
      @(negedge clk);
      hold = !bus.in_ready;
      cyc++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("bp");
    check("bp_sent",      n_sent - s0, 8);
    check("bp_recv",      n_recv - r0, 8);
    check("bp_inready_low", saw_block, 1);

    // Random traffic with random backpressure.
    s0 = n_sent;
    r0 = n_recv;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.a         = pick16();
      bus.b         = pick16();
      bus.cin       = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand");
    check("rand_count", n_recv - r0, n_sent - s0);

    // Reset while beats are in flight and a result is being presented.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.cin      = 1'($urandom);
      bus.sub      = 1'b0;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    check("prerst_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum",       bus.sum, 0);
    check("midrst_cout",      bus.cout, 0);
    check("midrst_ovf",       bus.ovf, 0);
    check("midrst_in_ready",  bus.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    beat(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "post_rst");
    repeat (6) @(negedge clk);
    check("post_rst_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
